// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbitration of two writeback requesters onto one
// register file write port, with a zeroing sweep after reset or on request.
module regfile_write_arbiter #(
  parameter int REG_NUM  = 32,
  parameter int REG_SIZE = 32,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [AW-1:0]       a_reg,
  input  logic [REG_SIZE-1:0] a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [AW-1:0]       b_reg,
  input  logic [REG_SIZE-1:0] b_data,
  output logic                b_ready,
  input  logic                clear_req,
  output logic                busy,
  output logic                reg_write,
  output logic [AW-1:0]       write_reg,
  output logic [REG_SIZE-1:0] write_data
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t        state, state_next;
  logic [AW-1:0] cnt, cnt_next;
  logic          rr, rr_next;
  logic          last;
  logic          a_wr, b_wr;
  assign last = cnt == AW'(REG_NUM - 1);
  // rr=0 favours A, rr=1 favours B when both request
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rr_next    = rr;
    busy       = state == CLEAR;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    if (state == CLEAR) begin
      cnt_next   = last ? '0 : cnt + 1'b1;
      state_next = last ? RUN : CLEAR;
    end else if (clear_req) begin
      cnt_next   = '0;
      state_next = CLEAR;
    end else begin
      a_ready = a_valid & (~b_valid | ~rr);
      b_ready = b_valid & (~a_valid | rr);
      rr_next = (a_valid & b_valid) ? ~rr : rr;
    end
  end
  // writes to register 0 are accepted but never reach the register file
  assign a_wr = a_ready & (|a_reg);
  assign b_wr = b_ready & (|b_reg);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CLEAR;
      cnt        <= '0;
      rr         <= 1'b0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      rr        <= rr_next;
      reg_write <= busy | a_wr | b_wr;
      if (busy) begin
        write_reg  <= cnt;
        write_data <= '0;
      end else if (a_wr) begin
        write_reg  <= a_reg;
        write_data <= a_data;
      end else if (b_wr) begin
        write_reg  <= b_reg;
        write_data <= b_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vector table plus hand-written sweep, clear and reset sequences.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, clear_req = 1'b0;
  logic [4:0]  a_reg = '0, b_reg = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, busy, reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  int          n_chk = 0, n_fail = 0;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .clear_req(clear_req), .busy(busy),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    logic        ea, eb, ew;
    logic [4:0]  er;
    logic [31:0] ed;
  } vec_t;
  vec_t v[12];

  function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad, logic bv, logic [4:0] br,
                              logic [31:0] bd, logic ea, logic eb, logic ew, logic [4:0] er, logic [31:0] ed);
    vec_t r;
    r.av = av; r.ar = ar; r.ad = ad; r.bv = bv; r.br = br; r.bd = bd;
    r.ea = ea; r.eb = eb; r.ew = ew; r.er = er; r.ed = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 32; i++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " a_ready"}, 32'(a_ready), 32'd0);
      @(posedge clk); #1;
      chk({tag, " reg_write"}, 32'(reg_write), 32'd1);
      chk({tag, " write_reg"}, 32'(write_reg), 32'(i));
      chk({tag, " write_data"}, write_data, 32'd0);
    end
    chk({tag, " busy end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    v[0]  = mk(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF);
    v[1]  = mk(1'b1, 5'd3,  32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b1, 1'b0, 1'b1, 5'd3,  32'h11111111);
    v[2]  = mk(1'b1, 5'd3,  32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0, 1'b1, 1'b1, 5'd7,  32'h22222222);
    v[3]  = mk(1'b1, 5'd3,  32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b1, 1'b0, 1'b1, 5'd3,  32'h11111111);
    v[4]  = mk(1'b1, 5'd3,  32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0, 1'b1, 1'b1, 5'd7,  32'h22222222);
    v[5]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd7,  32'h22222222);
    v[6]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h1234,     1'b0, 1'b1, 1'b0, 5'd7,  32'h22222222);
    v[7]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 5'd9,  32'hCAFEF00D);
    v[8]  = mk(1'b1, 5'd4,  32'hAAAA,     1'b1, 5'd4, 32'hBBBB,     1'b1, 1'b0, 1'b1, 5'd4,  32'hAAAA);
    v[9]  = mk(1'b1, 5'd4,  32'hAAAA,     1'b1, 5'd4, 32'hBBBB,     1'b0, 1'b1, 1'b1, 5'd4,  32'hBBBB);
    v[10] = mk(1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF);
    v[11] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd31, 32'hFFFFFFFF);

    #12;
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset reg_write", 32'(reg_write), 32'd0);
    chk("reset write_reg", 32'(write_reg), 32'd0);
    chk("reset a_ready", 32'(a_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    sweep_check("init sweep");
    @(posedge clk); #1;
    chk("post sweep idle reg_write", 32'(reg_write), 32'd0);

    foreach (v[i]) begin
      @(negedge clk);
      a_valid = v[i].av; a_reg = v[i].ar; a_data = v[i].ad;
      b_valid = v[i].bv; b_reg = v[i].br; b_data = v[i].bd;
      #1;
      chk($sformatf("vec%0d a_ready", i), 32'(a_ready), 32'(v[i].ea));
      chk($sformatf("vec%0d b_ready", i), 32'(b_ready), 32'(v[i].eb));
      @(posedge clk); #1;
      chk($sformatf("vec%0d reg_write", i), 32'(reg_write), 32'(v[i].ew));
      chk($sformatf("vec%0d write_reg", i), 32'(write_reg), 32'(v[i].er));
      chk($sformatf("vec%0d write_data", i), write_data, v[i].ed);
    end

    @(negedge clk);
    a_valid = 1'b1; a_reg = 5'd12; a_data = 32'h0BADF00D; b_valid = 1'b0; clear_req = 1'b1;
    #1;
    chk("clear a_ready", 32'(a_ready), 32'd0);
    chk("clear b_ready", 32'(b_ready), 32'd0);
    @(posedge clk); #1;
    chk("clear reg_write", 32'(reg_write), 32'd0);
    @(negedge clk);
    clear_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid sweep write_reg", 32'(write_reg), 32'd9);
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk); #1;
    chk("clear ignored write_reg", 32'(write_reg), 32'd10);
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 11; i < 32; i++) begin
      @(posedge clk); #1;
      chk("clear sweep write_reg", 32'(write_reg), 32'(i));
    end
    chk("clear sweep busy end", 32'(busy), 32'd0);
    chk("first run a_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    chk("first run reg_write", 32'(reg_write), 32'd1);
    chk("first run write_reg", 32'(write_reg), 32'd12);
    chk("first run write_data", write_data, 32'h0BADF00D);

    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 18; i++) @(posedge clk);
    #1;
    chk("pre abort write_reg", 32'(write_reg), 32'd17);
    #1;
    rst = 1'b0;
    #1;
    chk("abort reg_write", 32'(reg_write), 32'd0);
    chk("abort write_reg", 32'(write_reg), 32'd0);
    chk("abort busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    sweep_check("restart sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
